fir_decim_round: RTL

// - Output stage directly downstream of the 16-tap FIR low-pass (30-bit signed result, DC gain 2^15).
// - Decimates by 2^dec_log2, removes filter gain by rounding right-shift, saturates to OUT_W bits.
// - Emits a single-cycle dout_vld strobe for the readout/UART packer.
// - Discards FIR start-up transient after each enable.

---
 rtl/fir_decim_round.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fir_decim_round.sv
// FIR output stage: decimate by 2^dec_log2, rounding right-shift, saturate, strobe.
// Define FIR_DECIM_AVG_EN to sum each group (boxcar average) instead of picking its last sample.
module fir_decim_round #(
  parameter int unsigned IN_W     = 30,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 15,
  parameter int unsigned FILL_CYC = 18
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic [2:0]       dec_log2,
  input  logic [IN_W-1:0]  din,
  input  logic             sat_clr,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld,
  output logic             sat_flag
);

  localparam int unsigned XW = IN_W + 8;
  localparam int unsigned FW = $clog2(FILL_CYC + 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e               state_q;
  logic [2:0]           r_log2_q;
  logic [FW-1:0]        fill_cnt_q;
  logic [6:0]           grp_cnt_q;
  logic                 v1_q, v2_q;
  logic signed [XW-1:0] x_q, y_q;

  logic [6:0]           grp_last;
  logic                 closing;
  logic signed [XW-1:0] x_nxt, y_nxt, rnd;
  int unsigned          shift;
  logic                 sat;
  logic [OUT_W-1:0]     sat_val;

  assign grp_last = ~(7'h7f << r_log2_q);
  assign closing  = (state_q == StRun) && en && (grp_cnt_q == grp_last);

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned AW = IN_W + 7;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum;

  // First sample of a group restarts the sum rather than adding to a stale one.
  always_comb begin
    sum = AW'($signed(din));
    if (grp_cnt_q != 7'd0) sum = acc_q + AW'($signed(din));
  end
  assign x_nxt = XW'(sum);
  assign shift = SHIFT + 32'(r_log2_q);
`else
  assign x_nxt = XW'($signed(din));
  assign shift = SHIFT;
`endif

  always_comb begin
    rnd   = XW'(1) << (shift - 1);
    y_nxt = (x_q + rnd) >>> shift;
  end

  // Fits in OUT_W bits only if all bits from the output sign bit upward agree.
  always_comb begin
    sat     = !((&y_q[XW-1:OUT_W-1]) || !(|y_q[XW-1:OUT_W-1]));
    sat_val = y_q[XW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      r_log2_q   <= '0;
      fill_cnt_q <= '0;
      grp_cnt_q  <= '0;
`ifdef FIR_DECIM_AVG_EN
      acc_q      <= '0;
`endif
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      v1_q <= 1'b0;
      if (!en) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q    <= StFill;
            r_log2_q   <= dec_log2;
            fill_cnt_q <= '0;
          end
          // The enabling edge already discards one sample, hence FILL_CYC-2.
          StFill: begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            if (fill_cnt_q == FW'(FILL_CYC - 2)) begin
              state_q   <= StRun;
              grp_cnt_q <= '0;
            end
          end
          StRun: begin
            grp_cnt_q <= closing ? 7'd0 : grp_cnt_q + 7'd1;
`ifdef FIR_DECIM_AVG_EN
            acc_q     <= sum;
`endif
            if (closing) begin
              v1_q <= 1'b1;
              x_q  <= x_nxt;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Pipeline keeps draining regardless of en so closed groups still emit.
      v2_q <= v1_q;
      if (v1_q) y_q <= y_nxt;
      dout_vld <= v2_q;
      if (v2_q) dout <= sat ? sat_val : y_q[OUT_W-1:0];
      sat_flag <= (v2_q && sat) || (sat_flag && !sat_clr);
    end
  end

endmodule
